rom_port_arbiter: RTL and testbench

- Shares the single read port of the boot ROM (0xBFC00000–0xBFC00FFF, word-wide synchronous read) between two requesters: instruction fetch (IF) and the data-side load path (LD).
- Arbitrates between them, range- and alignment-checks each request, and returns one-cycle-latency responses tagged to the owning requester.
- Sits between the fetch stage / load unit and the ROM macro.

---
 rtl/rom_pkg.sv | 26 ++
 rtl/rom_arb_priority.sv | 50 +++++
 rtl/rom_port_arbiter.sv | 107 ++++++++++
 tb/tb_rom_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared boot-ROM constants, response-owner encoding
// and the address range/alignment check.
package rom_pkg;

  localparam logic [31:0] ROM_BASE = 32'hBFC0_0000;
  localparam int          ROM_AW   = 12;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } resp_owner_t;

  // Address hits the window above bit aw and is word aligned.
  function automatic logic rom_addr_ok(
    input logic [31:0] addr,
    input logic [31:0] base = ROM_BASE,
    input int unsigned aw   = ROM_AW
  );
    logic [31:0] mask;
    mask = ~((32'd1 << aw) - 32'd1);
    return (((addr ^ base) & mask) == 32'd0) &&
           (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/rom_arb_priority.sv
// Grant selection between fetch and load, with a bounded
// load streak so a waiting fetch is never starved.
module rom_arb_priority #(
  parameter int MAX_LD_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ld_req,
  output logic if_gnt,
  output logic ld_gnt
);

  localparam int SW = $clog2(MAX_LD_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LD_STREAK);

  logic [SW-1:0] r_streak;
  logic          w_ld_win;

  // Load wins a contended cycle until the streak limit is hit.
  always_comb begin
    w_ld_win = (r_streak < STREAK_MAX);
    if_gnt   = 1'b0;
    ld_gnt   = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        (ld_req && !if_req): ld_gnt = 1'b1;
        (if_req && !ld_req): if_gnt = 1'b1;
        (ld_req && if_req): begin
          ld_gnt = w_ld_win;
          if_gnt = !w_ld_win;
        end
        default: ;
      endcase
    end
  end

  // Count loads granted over a waiting fetch; any other cycle clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (ld_gnt && if_req) begin
      if (r_streak != STREAK_MAX)
        r_streak <= r_streak + 1'b1;
    end else begin
      r_streak <= '0;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Boot-ROM read port shared by fetch and load; one-cycle
// tagged responses with range/alignment faults.
module rom_port_arbiter #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] ROM_BASE      = 32'hBFC0_0000,
  parameter int          ROM_AW        = 12,
  parameter int          MAX_LD_STREAK = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  input  logic                     if_flush,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  output logic                     if_fault,
  input  logic                     ld_req,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  output logic                     ld_gnt,
  output logic                     ld_rvalid,
  output logic [DATA_WIDTH-1:0]    ld_rdata,
  output logic                     ld_fault,
  output logic                     rom_en,
  output logic [ROM_AW-3:0]        rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_rdata
);

  import rom_pkg::*;

  logic        w_if_gnt;
  logic        w_ld_gnt;
  logic        w_if_ok;
  logic        w_ld_ok;
  resp_owner_t w_owner_nxt;
  logic        w_fault_nxt;
  resp_owner_t r_owner;
  logic        r_fault;
  logic        w_if_own;
  logic        w_ld_own;

  rom_arb_priority #(
    .MAX_LD_STREAK(MAX_LD_STREAK)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .if_req(if_req),
    .ld_req(ld_req),
    .if_gnt(w_if_gnt),
    .ld_gnt(w_ld_gnt)
  );

  assign if_gnt  = w_if_gnt;
  assign ld_gnt  = w_ld_gnt;
  assign w_if_ok = rom_addr_ok(if_addr, ROM_BASE, ROM_AW);
  assign w_ld_ok = rom_addr_ok(ld_addr, ROM_BASE, ROM_AW);

  // Route the granted address to the ROM and stage the response tag.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_fault_nxt = 1'b0;
    rom_en      = 1'b0;
    rom_addr    = '0;
    unique case (1'b1)
      w_if_gnt: begin
        w_owner_nxt = OWN_IF;
        w_fault_nxt = !w_if_ok;
        rom_en      = w_if_ok;
        if (w_if_ok)
          rom_addr = if_addr[ROM_AW-1:2];
      end
      w_ld_gnt: begin
        w_owner_nxt = OWN_LD;
        w_fault_nxt = !w_ld_ok;
        rom_en      = w_ld_ok;
        if (w_ld_ok)
          rom_addr = ld_addr[ROM_AW-1:2];
      end
      default: ;
    endcase
  end

  // Response tag register, lined up with the ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_fault <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Steer the response to its owner; reset discards a pending one.
  always_comb begin
    w_if_own  = (r_owner == OWN_IF) && !rst;
    w_ld_own  = (r_owner == OWN_LD) && !rst;
    if_rvalid = w_if_own && !if_flush;
    if_fault  = w_if_own && r_fault && !if_flush;
    if_rdata  = (w_if_own && !r_fault) ? rom_rdata : '0;
    ld_rvalid = w_ld_own;
    ld_fault  = w_ld_own && r_fault;
    ld_rdata  = (w_ld_own && !r_fault) ? rom_rdata : '0;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a
// synchronous-read ROM model.
module tb_rom_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_fault;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_fault;
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;

  logic [31:0] mem [0:1023];
  int checks;
  int failures;

  rom_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_fault (if_fault),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_gnt   (ld_gnt),
    .ld_rvalid(ld_rvalid),
    .ld_rdata (ld_rdata),
    .ld_fault (ld_fault),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_rdata(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rom_en)
      rom_rdata <= mem[rom_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req   = 1'b0;
    ld_req   = 1'b0;
    if_flush = 1'b0;
    if_addr  = 32'h0;
    ld_addr  = 32'h0;
  endtask

  bit exp_ld [5];
  bit exp_l2 [4];

  initial begin
    checks    = 0;
    failures  = 0;
    rom_rdata = 32'h0;
    for (int i = 0; i < 1024; i++)
      mem[i] = 32'hC0DE_0000 | i;
    mem[1] = 32'h0050_0093;

    // reset with both requesting
    idle();
    rst     = 1'b1;
    if_req  = 1'b1;
    ld_req  = 1'b1;
    if_addr = 32'hBFC0_0004;
    ld_addr = 32'hBFC0_0008;
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_ld_gnt", 32'(ld_gnt), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_if_rv", 32'(if_rvalid), 0);
    chk("rst_ld_rv", 32'(ld_rvalid), 0);
    chk("rst_if_rd", if_rdata, 0);
    chk("rst_ld_flt", 32'(ld_fault), 0);
    nxt();
    rst = 1'b0;
    idle();
    nxt();

    // single fetch
    if_req  = 1'b1;
    if_addr = 32'hBFC0_0004;
    @(negedge clk);
    chk("t1_gnt", 32'(if_gnt), 1);
    chk("t1_rom_en", 32'(rom_en), 1);
    chk("t1_rom_addr", 32'(rom_addr), 1);
    nxt();
    idle();
    @(negedge clk);
    chk("t1_rv", 32'(if_rvalid), 1);
    chk("t1_rd", if_rdata, 32'h0050_0093);
    chk("t1_flt", 32'(if_fault), 0);
    chk("t1_ld_rv", 32'(ld_rvalid), 0);
    nxt();

    // contention: LD LD LD IF LD
    exp_ld = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if_req  = 1'b1;
      ld_req  = 1'b1;
      if_addr = 32'hBFC0_0008;
      ld_addr = 32'hBFC0_0010;
      @(negedge clk);
      chk("t2_ld_gnt", 32'(ld_gnt), 32'(exp_ld[i]));
      chk("t2_if_gnt", 32'(if_gnt), 32'(!exp_ld[i]));
      if (i == 0) begin
        chk("t2_rv0", 32'({if_rvalid, ld_rvalid}), 0);
      end else begin
        chk("t2_ld_rv", 32'(ld_rvalid), 32'(exp_ld[i-1]));
        chk("t2_if_rv", 32'(if_rvalid), 32'(!exp_ld[i-1]));
        chk("t2_rd",
            exp_ld[i-1] ? ld_rdata : if_rdata,
            exp_ld[i-1] ? 32'hC0DE_0004 : 32'hC0DE_0002);
      end
      nxt();
    end
    idle();
    @(negedge clk);
    chk("t2_last_ld_rv", 32'(ld_rvalid), 1);
    chk("t2_last_ld_rd", ld_rdata, 32'hC0DE_0004);
    chk("t2_last_if_rv", 32'(if_rvalid), 0);
    nxt();

    // out-of-range then misaligned fetch
    if_req  = 1'b1;
    if_addr = 32'h0000_0000;
    @(negedge clk);
    chk("t3_gnt_a", 32'(if_gnt), 1);
    chk("t3_en_a", 32'(rom_en), 0);
    chk("t3_addr_a", 32'(rom_addr), 0);
    nxt();
    if_addr = 32'hBFC0_0002;
    @(negedge clk);
    chk("t3_gnt_b", 32'(if_gnt), 1);
    chk("t3_en_b", 32'(rom_en), 0);
    chk("t3_rv_a", 32'(if_rvalid), 1);
    chk("t3_flt_a", 32'(if_fault), 1);
    chk("t3_rd_a", if_rdata, 0);
    nxt();
    idle();
    @(negedge clk);
    chk("t3_rv_b", 32'(if_rvalid), 1);
    chk("t3_flt_b", 32'(if_fault), 1);
    chk("t3_rd_b", if_rdata, 0);
    nxt();

    // back-to-back loads at window edges
    ld_req  = 1'b1;
    ld_addr = 32'hBFC0_0FFC;
    @(negedge clk);
    chk("t4_gnt0", 32'(ld_gnt), 1);
    chk("t4_addr0", 32'(rom_addr), 1023);
    nxt();
    ld_addr = 32'hBFC0_0000;
    @(negedge clk);
    chk("t4_addr1", 32'(rom_addr), 0);
    chk("t4_rv0", 32'(ld_rvalid), 1);
    chk("t4_rd0", ld_rdata, 32'hC0DE_03FF);
    nxt();
    ld_addr = 32'hBFC0_0008;
    @(negedge clk);
    chk("t4_addr2", 32'(rom_addr), 2);
    chk("t4_rv1", 32'(ld_rvalid), 1);
    chk("t4_rd1", ld_rdata, 32'hC0DE_0000);
    nxt();
    idle();
    @(negedge clk);
    chk("t4_rv2", 32'(ld_rvalid), 1);
    chk("t4_rd2", ld_rdata, 32'hC0DE_0002);
    chk("t4_flt2", 32'(ld_fault), 0);
    nxt();

    // flush drops old response, not the new grant's
    if_req  = 1'b1;
    if_addr = 32'hBFC0_0004;
    @(negedge clk);
    chk("t5_gnt0", 32'(if_gnt), 1);
    nxt();
    if_addr  = 32'hBFC0_000C;
    if_flush = 1'b1;
    @(negedge clk);
    chk("t5_gnt1", 32'(if_gnt), 1);
    chk("t5_flush_rv", 32'(if_rvalid), 0);
    chk("t5_flush_flt", 32'(if_fault), 0);
    nxt();
    idle();
    @(negedge clk);
    chk("t5_rv", 32'(if_rvalid), 1);
    chk("t5_rd", if_rdata, 32'hC0DE_0003);
    nxt();

    // reset mid-stream clears pending response and streak
    for (int i = 0; i < 2; i++) begin
      if_req  = 1'b1;
      ld_req  = 1'b1;
      if_addr = 32'hBFC0_0008;
      ld_addr = 32'hBFC0_0010;
      @(negedge clk);
      chk("t6_pre_ld", 32'(ld_gnt), 1);
      nxt();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_gnt", 32'({if_gnt, ld_gnt}), 0);
    chk("t6_rst_rv", 32'(ld_rvalid), 0);
    nxt();
    rst = 1'b0;
    exp_l2 = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_ld_gnt", 32'(ld_gnt), 32'(exp_l2[i]));
      chk("t6_if_gnt", 32'(if_gnt), 32'(!exp_l2[i]));
      if (i == 0)
        chk("t6_post_rv", 32'({if_rvalid, ld_rvalid}), 0);
      nxt();
    end
    idle();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
